// File: rtl/core_dmem_bridge.sv
// core_dmem_bridge
// Registered bridge between the LSU data port (req/gnt) and the external data
// bus (request valid/ready, response valid). One transaction at a time; a
// response timeout turns a hung bus into a bus error for the LSU, and the late
// response is then drained and discarded.

module core_dmem_bridge #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        dmem_req,
    input  logic [63:0] dmem_addr,
    input  logic        dmem_wen,
    input  logic [7:0]  dmem_strb,
    input  logic [63:0] dmem_wdata,
    output logic        dmem_gnt,
    output logic        dmem_err,
    output logic [63:0] dmem_rdata,

    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [63:0] bus_req_addr,
    output logic        bus_req_wen,
    output logic [7:0]  bus_req_strb,
    output logic [63:0] bus_req_wdata,
    input  logic        bus_rsp_valid,
    input  logic        bus_rsp_err,
    input  logic [63:0] bus_rsp_rdata,

    output logic        timeout
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RSP   = 3'd2,
        ST_GNT   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    // Counter value seen in the last RSP cycle before the forced error.
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE      = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    state_t               state_r;
    logic [TIMEOUT_W-1:0] cnt_r;

    // Transaction state machine; every output is a register updated here.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {TIMEOUT_W{1'b0}};
            dmem_gnt      <= 1'b0;
            dmem_err      <= 1'b0;
            dmem_rdata    <= 64'd0;
            bus_req_valid <= 1'b0;
            bus_req_addr  <= 64'd0;
            bus_req_wen   <= 1'b0;
            bus_req_strb  <= 8'd0;
            bus_req_wdata <= 64'd0;
            timeout       <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses unless set below.
            dmem_gnt <= 1'b0;
            dmem_err <= 1'b0;
            timeout  <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (dmem_req) begin
                        bus_req_addr  <= dmem_addr;
                        bus_req_wen   <= dmem_wen;
                        bus_req_strb  <= dmem_strb;
                        bus_req_wdata <= dmem_wdata;
                        bus_req_valid <= 1'b1;
                        state_r       <= ST_REQ;
                    end else begin
                        state_r       <= ST_IDLE;
                    end
                end

                // Request held stable until the bus accepts it; no timeout here.
                ST_REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        cnt_r         <= {TIMEOUT_W{1'b0}};
                        state_r       <= ST_RSP;
                    end else begin
                        state_r       <= ST_REQ;
                    end
                end

                // A response in the same cycle as the timeout takes priority.
                ST_RSP: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (bus_rsp_valid) begin
                        dmem_rdata <= bus_rsp_rdata;
                        dmem_err   <= bus_rsp_err;
                        dmem_gnt   <= 1'b1;
                        state_r    <= ST_GNT;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        dmem_rdata <= 64'd0;
                        dmem_err   <= 1'b1;
                        dmem_gnt   <= 1'b1;
                        timeout    <= 1'b1;
                        state_r    <= ST_DRAIN;
                    end else begin
                        state_r    <= ST_RSP;
                    end
                end

                // LSU still holds the completed request; do not reissue it.
                ST_GNT: begin
                    state_r <= ST_HOLD;
                end

                ST_HOLD: begin
                    state_r <= ST_IDLE;
                end

                // Swallow the late response of a timed-out transaction.
                ST_DRAIN: begin
                    if (bus_rsp_valid) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end

                default: begin
                    bus_req_valid <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
